serv_rf_dbg_arb: RTL
====================

SERV_RF_DBG_ARB -- requirements
Module: serv_rf_dbg_arb

Interface
REQ-001 One clock; reset is asynchronous and active-low; ports are named i_clk and i_rst_n.
REQ-002 Parameter: DBG_ADDR_W, default 6, is the debug register address width (0-31 GPR, 32-63 unsupported).
REQ-003 i_clk  in  1  clock.
REQ-004 i_rst_n  in  1  async active-low reset.
REQ-005 Core serial port in: i_core_rreg1 6, i_core_wreg0 6, i_core_wen0 1, i_core_wdata0 1, i_core_rreq 1; out: o_core_ready 1, o_core_rdata1 1.
REQ-006 RF side out: o_rf_rreg1 6, o_rf_wreg0 6, o_rf_wen0 1, o_rf_wdata0 1, o_rf_rreq 1; in: i_rf_ready 1, i_rf_rdata1 1.
REQ-007 i_halted  in  1  core halted in debug mode; debug access is permitted only while it is high.
REQ-008 Debug port: i_dbg_req 1, i_dbg_we 1, i_dbg_addr DBG_ADDR_W, i_dbg_wdata 32 in; o_dbg_ack 1, o_dbg_err 1, o_dbg_rdata 32 out.

Function
REQ-009 States: IDLE, RREQ, RWAIT, RSHIFT, WSHIFT, ACK; a 5-bit bit counter; a 32-bit shift register.
REQ-010 In IDLE, core signals SHALL pass straight through to the RF side, and RF signals SHALL pass straight through to the core (o_core_ready=i_rf_ready, o_core_rdata1=i_rf_rdata1).
REQ-011 Debug accept in IDLE: i_dbg_req & i_halted & ~i_core_rreq & ~i_core_wen0. If i_halted=0, the request SHALL wait with no ack.
REQ-012 On accept, the block SHALL latch the address, we and wdata; while the state is not IDLE, the block SHALL own the RF, force o_core_ready=0, and ignore i_dbg_req.
REQ-013 On accept with addr[5]=1, the next state SHALL be ACK with o_dbg_err=1 and no RF access.
REQ-014 Write accept with addr=0 (x0): the block SHALL go to ACK with err=0 and no wen.
REQ-015 Read path, where T is the accept cycle:
  - T+1: RREQ; o_rf_rreq=1 for exactly one cycle; o_rf_rreg1={1'b0,addr[4:0]}.
  - Then RWAIT until i_rf_ready=1; i_rf_ready is sampled from the RREQ cycle onward.
  - The cycle after ready: RSHIFT for 32 cycles; each cycle shifts i_rf_rdata1 into bit 31; LSB arrives first.
REQ-016 Read of addr 0 SHALL return o_dbg_rdata=0 regardless of RF data. The RF read SHALL still be performed.
REQ-017 Write path: T+1 to T+32 is WSHIFT.
  - o_rf_wen0=1 and o_rf_wreg0={1'b0,addr[4:0]}.
  - o_rf_wdata0=shift[0], shifting right each cycle; LSB first.
  - The counter wraps 31->0 and then the state goes to ACK.
REQ-018 ACK lasts one cycle: o_dbg_ack=1; o_dbg_err as decided; next state IDLE.
  - o_dbg_rdata is updated at ACK for reads only and SHALL hold until the next read ACK.
  - Write latency: ack at T+33. Read latency: ack at T+34+W, where W is the number of RWAIT cycles.
REQ-019 A core i_core_rreq raised while the state is not IDLE SHALL be latched as pending, then issued as o_rf_rreq in the first IDLE cycle. The core's own i_core_rreq that cycle SHALL be OR-ed with it, and the pending flag cleared.
REQ-020 If i_halted falls mid-operation, the operation SHALL complete normally; no abort.
REQ-021 Simultaneous i_dbg_req and i_core_rreq in IDLE: the core wins, and debug waits.
REQ-022 Outside debug ownership, o_rf_wen0 SHALL equal i_core_wen0 combinationally; in ownership it SHALL equal only the debug wen.

Reset
REQ-023 While i_rst_n=0, the block SHALL hold:
  - State IDLE, counter 0, shift register 0, pending 0.
  - o_dbg_ack=0, o_dbg_err=0, o_dbg_rdata=0.
  - o_rf_rreq and o_rf_wen0 equal to the (gated) core inputs.
REQ-024 Reset asserted mid-operation SHALL abort immediately: no further wen, and no ack after release.

Verification
REQ-025 Halted, write addr 5, data 0xA5A5_0F0F -> 32 cycles of wen0 with wreg0=5; the serial stream equals the data LSB-first; ack at T+33 with err=0.
REQ-026 Halted, read addr 5; RF model gives ready 2 cycles after rreq and streams 0x1234_5678 -> o_dbg_rdata=0x1234_5678, ack once, o_core_ready=0 throughout.
REQ-027 Write addr 0 -> no wen and ack at T+1; read addr 40 -> ack with err=1 and no o_rf_rreq.
REQ-028 Core rreq pulse during WSHIFT -> exactly one o_rf_rreq issued in the first IDLE cycle after ACK.
REQ-029 i_dbg_req with i_halted=0 for 10 cycles -> no ack; raise halted -> accept the next cycle.
REQ-030 Assert i_rst_n=0 at WSHIFT cycle 10 -> wen drops the same cycle; no ack after release; next request serviced normally.

Source files
------------

// File: rtl/serv_rf_dbg_arb_if.sv
// rtl/serv_rf_dbg_arb_if.sv - core, register-file and debug signal bundle for serv_rf_dbg_arb
interface serv_rf_dbg_arb_if #(
   parameter int DBG_ADDR_W = 6
);
   logic [5:0]            i_core_rreg1;
   logic [5:0]            i_core_wreg0;
   logic                  i_core_wen0;
   logic                  i_core_wdata0;
   logic                  i_core_rreq;
   logic                  o_core_ready;
   logic                  o_core_rdata1;

   logic [5:0]            o_rf_rreg1;
   logic [5:0]            o_rf_wreg0;
   logic                  o_rf_wen0;
   logic                  o_rf_wdata0;
   logic                  o_rf_rreq;
   logic                  i_rf_ready;
   logic                  i_rf_rdata1;

   logic                  i_dbg_req;
   logic                  i_dbg_we;
   logic [DBG_ADDR_W-1:0] i_dbg_addr;
   logic [31:0]           i_dbg_wdata;
   logic                  o_dbg_ack;
   logic                  o_dbg_err;
   logic [31:0]           o_dbg_rdata;

   modport slave (
      input  i_core_rreg1, i_core_wreg0, i_core_wen0, i_core_wdata0, i_core_rreq,
      output o_core_ready, o_core_rdata1,
      output o_rf_rreg1, o_rf_wreg0, o_rf_wen0, o_rf_wdata0, o_rf_rreq,
      input  i_rf_ready, i_rf_rdata1,
      input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      output o_dbg_ack, o_dbg_err, o_dbg_rdata
   );

   modport master (
      output i_core_rreg1, i_core_wreg0, i_core_wen0, i_core_wdata0, i_core_rreq,
      input  o_core_ready, o_core_rdata1,
      input  o_rf_rreg1, o_rf_wreg0, o_rf_wen0, o_rf_wdata0, o_rf_rreq,
      output i_rf_ready, i_rf_rdata1,
      output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      input  o_dbg_ack, o_dbg_err, o_dbg_rdata
   );
endinterface

// File: rtl/serv_rf_dbg_arb.sv
// rtl/serv_rf_dbg_arb.sv - arbitrates the serial register file between the core and a halted-mode debug port
module serv_rf_dbg_arb #(
   parameter int DBG_ADDR_W = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_halted,
   serv_rf_dbg_arb_if.slave      bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_RREQ, S_RWAIT, S_RSHIFT, S_WSHIFT, S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [4:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        pend_q, pend_d;
   logic [31:0] rdata_q, rdata_d;
   logic        accept;
   logic        owned;

   // A pending core read counts as a core request, so it also keeps debug out.
   assign accept = (state_q == S_IDLE) & bus.i_dbg_req & i_halted & ~bus.i_core_rreq
                 & ~bus.i_core_wen0 & ~pend_q;
   assign owned  = (state_q != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         shift_q <= 32'd0;
         addr_q  <= 5'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      we_d    = we_q;
      err_d   = err_q;
      pend_d  = pend_q | bus.i_core_rreq;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            pend_d = 1'b0;
            if (accept) begin
               addr_d  = bus.i_dbg_addr[4:0];
               we_d    = bus.i_dbg_we;
               shift_d = bus.i_dbg_wdata;
               cnt_d   = 5'd0;
               err_d   = |bus.i_dbg_addr[DBG_ADDR_W-1:5];
               if (err_d || (bus.i_dbg_we && bus.i_dbg_addr[4:0] == 5'd0))
                  state_d = S_ACK;
               else if (bus.i_dbg_we)
                  state_d = S_WSHIFT;
               else
                  state_d = S_RREQ;
            end
         end
         S_RREQ, S_RWAIT: begin
            cnt_d   = 5'd0;
            state_d = bus.i_rf_ready ? S_RSHIFT : S_RWAIT;
         end
         S_RSHIFT: begin
            shift_d = {bus.i_rf_rdata1, shift_q[31:1]};
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_ACK;
               // x0 reads as zero even though the RF access still happens.
               rdata_d = (addr_q == 5'd0) ? 32'd0 : shift_d;
            end
         end
         S_WSHIFT: begin
            shift_d = {1'b0, shift_q[31:1]};
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.o_core_ready  = bus.i_rf_ready;
      bus.o_core_rdata1 = bus.i_rf_rdata1;
      bus.o_rf_rreg1    = bus.i_core_rreg1;
      bus.o_rf_wreg0    = bus.i_core_wreg0;
      bus.o_rf_wen0     = bus.i_core_wen0;
      bus.o_rf_wdata0   = bus.i_core_wdata0;
      bus.o_rf_rreq     = bus.i_core_rreq | pend_q;
      if (owned) begin
         bus.o_core_ready  = 1'b0;
         bus.o_core_rdata1 = 1'b0;
         bus.o_rf_rreg1    = {1'b0, addr_q};
         bus.o_rf_wreg0    = {1'b0, addr_q};
         bus.o_rf_wen0     = (state_q == S_WSHIFT);
         bus.o_rf_wdata0   = shift_q[0];
         bus.o_rf_rreq     = (state_q == S_RREQ);
      end
      bus.o_dbg_ack   = (state_q == S_ACK);
      bus.o_dbg_err   = (state_q == S_ACK) & err_q;
      bus.o_dbg_rdata = rdata_q;
   end
endmodule
